skew_result_collector: RTL
==========================

Name: skew_result_collector

Overview:
- Receiving end of the systolic datapath. The transpose feeder launches matrix rows into the array with a diagonal skew. This block collects the skewed per-column results leaving the array.
- Each lane is de-skewed with a per-lane delay line. Aligned result rows are written into a DEPTH x DEPTH result buffer.
- Any stored row can be read back by index once collection is complete, or at any time.

Parameters:
- DEPTH, 8, matrix dimension: number of lanes, rows stored and words per row.
- BITS, 16, width of one result element (accumulator width).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle pulse: clear buffer pointers and flags, flush delay lines, arm collection.
- in_valid  input  DEPTH  per-lane valid; lane i is skewed i cycles behind lane 0.
- Cin  input  BITS x DEPTH (unpacked [DEPTH-1:0])  per-lane result element.
- rd_en  input  1  read request.
- Crow  input  $clog2(DEPTH)  row index to read.
- Cout  output  BITS x DEPTH (unpacked [DEPTH-1:0])  registered read row.
- rd_valid  output  1  high the cycle after an accepted rd_en.
- busy  output  1  high in COLLECT.
- full  output  1  high in FULL: all DEPTH rows captured.
- err  output  1  sticky: misaligned row or overflow since the last start or reset.

Behaviour:
- Reset (rst high at posedge):
  - state=IDLE, wr_row=0.
  - All delay-line data/valid registers are cleared to 0; all buffer entries are cleared to 0.
  - Cout=0, rd_valid=0, busy=0, full=0, err=0.
- Delay lines:
  - Lane i passes {in_valid[i], Cin[i]} through DEPTH-1-i registers. Lane DEPTH-1 has zero delay (combinational pass).
  - The registers shift every cycle regardless of state.
- Aligned row:
  - row_all = AND of all delayed valids; row_any = OR of all delayed valids.
- States:
  - IDLE: aligned rows are ignored; a row_any pulse sets err.
  - COLLECT:
    - row_all=1: write the delayed lanes to buf[wr_row] at the posedge, then wr_row++.
    - Writing row DEPTH-1 moves to FULL in the same edge; full=1 from the next cycle.
    - row_any=1 with row_all=0: no write, err=1, stay in COLLECT.
  - FULL: buffer is frozen; row_any=1 sets err (overflow); no write.
- start, from any state:
  - Go to COLLECT: wr_row=0, full=0, err=0, delay lines flushed to 0. Buffer contents are kept.
  - start has priority over a same-cycle write, which is dropped.
- Latency: a lane-0 sample presented at edge t is visible in the buffer after edge t+DEPTH-1. It is readable with rd_en at cycle t+DEPTH-1, giving Cout at t+DEPTH.
- Read:
  - rd_en=1 at edge t: Cout <= buf[Crow] and rd_valid=1 during cycle t+1.
  - rd_en=0: rd_valid=0 and Cout holds its value.
  - Reads are legal in every state.
  - A same-edge read of a row being written returns the old contents (no bypass).
- Crow is always in range since DEPTH is a power of two; other DEPTH values are unsupported.
- rst while in COLLECT aborts collection; the next start is required.

Decomposition:
- Shared package: state enum {IDLE, COLLECT, FULL}.
- Sub-module skew_delay_line (params LEN, BITS; ports clk, rst, vin, din, vout, dout; LEN=0 means passthrough). Instantiate DEPTH copies via generate.

Test Plan:
- Reset then read rows 0..7 -> Cout all zero, rd_valid one cycle after each rd_en, busy=full=err=0.
- start, then drive a correctly skewed 8x8 stream with C[r][c]=16*r+c (lane c valid from cycle c to c+7) -> full asserts 8 cycles after the last lane-0 sample. Reading Crow=3 gives {0x30..0x37}, err=0.
- In COLLECT, assert in_valid[5] one cycle late for row 2 -> err=1, the misaligned row is not written, and wr_row does not advance for it.
- After full, drive an extra aligned row -> err=1, buffer unchanged (row 0 still 0x00..0x07).
- start asserted in the same cycle as an aligned row -> write dropped, wr_row=0, err=0, busy=1. A fresh 8-row stream then fills normally.
- rst mid-collection after 4 rows -> state IDLE and buffer zero. Aligned input afterwards without start sets err and writes nothing.

Source files
------------

// File: rtl/skew_result_collector_pkg.sv
// Shared types for the systolic result collector.
// Latency: n/a (types only).
// Backpressure: n/a.
package skew_result_collector_pkg;

    // Collector control states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } state_t;

endpackage

// File: rtl/skew_result_collector_delay.sv
// Per-lane de-skew delay line: {vin, din} delayed by LEN registers, LEN=0 is a wire.
// Latency: LEN cycles. Shifts every cycle; rst clears every stage to zero.
// Backpressure: none, free-running shift register.
// Ports: clk, rst (sync, active-high, also used as flush), vin/din in, vout/dout out.
module skew_delay_line #(
    parameter int LEN  = 0,
    parameter int BITS = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            vin,
    input  logic [BITS-1:0] din,
    output logic            vout,
    output logic [BITS-1:0] dout
);

    if (LEN == 0) begin : g_pass
        // Last lane is already aligned; clock and reset are not needed.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign vout = vin;
        assign dout = din;
    end else begin : g_pipe
        logic [LEN-1:0]  vld_q;
        logic [LEN-1:0]  vld_d;
        logic [BITS-1:0] dat_q [LEN];
        logic [BITS-1:0] dat_d [LEN];

        always_comb begin
            vld_d    = vld_q;
            dat_d    = dat_q;
            vld_d[0] = vin;
            dat_d[0] = din;
            for (int k = 1; k < LEN; k++) begin
                vld_d[k] = vld_q[k-1];
                dat_d[k] = dat_q[k-1];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= '0;
                for (int k = 0; k < LEN; k++) begin
                    dat_q[k] <= '0;
                end
            end else begin
                vld_q <= vld_d;
                dat_q <= dat_d;
            end
        end

        assign vout = vld_q[LEN-1];
        assign dout = dat_q[LEN-1];
    end

endmodule

// File: rtl/skew_result_collector.sv
// Collects diagonally skewed column results from the systolic array, de-skews them and stores rows in a DEPTHxDEPTH buffer.
// Latency: lane-0 sample at edge t lands in the buffer at edge t+DEPTH-1; reads return Cout one cycle after rd_en.
// Backpressure: none; misaligned rows and rows arriving outside COLLECT set the sticky err flag and are dropped.
// Ports: clk, rst, start, in_valid/Cin (skewed lanes), rd_en/Crow (read request), Cout/rd_valid (read data), busy/full/err (status).
module skew_result_collector
    import skew_result_collector_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int BITS  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [DEPTH-1:0]         in_valid,
    input  logic [BITS-1:0]          Cin [DEPTH-1:0],
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] Crow,
    output logic [BITS-1:0]          Cout [DEPTH-1:0],
    output logic                     rd_valid,
    output logic                     busy,
    output logic                     full,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);

    // start flushes the delay lines just like reset does.
    logic             flush;
    logic [DEPTH-1:0] dly_vld;
    logic [BITS-1:0]  dly_dat [DEPTH-1:0];
    logic             row_all;
    logic             row_any;

    assign flush = rst | start;

    // Lane i trails lane 0 by i cycles, so it needs DEPTH-1-i stages to line up.
    for (genvar i = 0; i < DEPTH; i++) begin : g_lane
        skew_delay_line #(
            .LEN  (DEPTH - 1 - i),
            .BITS (BITS)
        ) u_dly (
            .clk  (clk),
            .rst  (flush),
            .vin  (in_valid[i]),
            .din  (Cin[i]),
            .vout (dly_vld[i]),
            .dout (dly_dat[i])
        );
    end

    assign row_all = &dly_vld;
    assign row_any = |dly_vld;

    state_t          state_q,  state_d;
    logic [AW-1:0]   wr_row_q, wr_row_d;
    logic            err_q,    err_d;
    logic            rd_valid_q, rd_valid_d;
    logic [BITS-1:0] cout_q [DEPTH-1:0];
    logic [BITS-1:0] cout_d [DEPTH-1:0];
    logic [BITS-1:0] res_buf_q [DEPTH-1:0][DEPTH-1:0];
    logic [BITS-1:0] res_buf_d [DEPTH-1:0][DEPTH-1:0];
    logic            wr_en;

    always_comb begin
        state_d   = state_q;
        wr_row_d  = wr_row_q;
        err_d     = err_q;
        res_buf_d = res_buf_q;
        wr_en     = 1'b0;

        if (start) begin
            // start wins over any row completing this cycle; that row is dropped.
            state_d  = COLLECT;
            wr_row_d = '0;
            err_d    = 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (row_all) begin
                        wr_en    = 1'b1;
                        wr_row_d = wr_row_q + AW'(1);
                        if (wr_row_q == AW'(DEPTH - 1)) begin
                            state_d = FULL;
                        end
                    end else if (row_any) begin
                        err_d = 1'b1;
                    end
                end
                // Any arriving data outside COLLECT is unexpected.
                default: begin
                    if (row_any) begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end

        if (wr_en) begin
            res_buf_d[wr_row_q] = dly_dat;
        end
    end

    // Read port sees the pre-write buffer contents (no write bypass).
    always_comb begin
        rd_valid_d = rd_en;
        cout_d     = cout_q;
        if (rd_en) begin
            cout_d = res_buf_q[Crow];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_row_q   <= '0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            for (int r = 0; r < DEPTH; r++) begin
                cout_q[r] <= '0;
                for (int c = 0; c < DEPTH; c++) begin
                    res_buf_q[r][c] <= '0;
                end
            end
        end else begin
            state_q    <= state_d;
            wr_row_q   <= wr_row_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
            cout_q     <= cout_d;
            res_buf_q  <= res_buf_d;
        end
    end

    assign Cout     = cout_q;
    assign rd_valid = rd_valid_q;
    assign busy     = (state_q == COLLECT);
    assign full     = (state_q == FULL);
    assign err      = err_q;

endmodule
